// File: rtl/bp_history_ctrl_if.sv
// bp_history_ctrl_if: fetch-side, resolve-side and PHT-update signals of the
// gshare history controller, bundled so the pipeline and the controller
// share one connection.
//
// Handshake semantics (valid/ready):
//   - A predicted branch is pushed on a clock edge where pred_fire && pred_ready.
//     pred_ready depends only on registered state, never on pred_fire.
//   - A resolution is consumed on a clock edge where resolve_valid is high
//     and at least one branch is in flight. With nothing in flight it is
//     silently ignored, so the resolve side has no ready signal.
//   - flush is a level sampled on the clock edge. It takes priority over a
//     push in the same cycle.
interface bp_history_ctrl_if #(
    parameter int GHR_WIDTH = 5
);
    // Fetch side
    logic [31:0]          fetch_pc;
    logic [GHR_WIDTH-1:0] index;
    logic                 pred_taken;
    logic                 pred_fire;
    logic                 pred_ready;
    // Resolve side
    logic                 resolve_valid;
    logic                 resolve_taken;
    logic                 flush;
    // PHT update and trace
    logic                 is_last_branch;
    logic                 is_last_taken;
    logic [GHR_WIDTH-1:0] last_index;
    logic                 mispredict;
    logic [GHR_WIDTH-1:0] spec_ghr_out;

    // Pipeline side: drives fetch/resolve requests and observes the update.
    modport master (
        output fetch_pc, pred_taken, pred_fire,
        output resolve_valid, resolve_taken, flush,
        input  index, pred_ready,
        input  is_last_branch, is_last_taken, last_index, mispredict,
        input  spec_ghr_out
    );

    // Controller side.
    modport slave (
        input  fetch_pc, pred_taken, pred_fire,
        input  resolve_valid, resolve_taken, flush,
        output index, pred_ready,
        output is_last_branch, is_last_taken, last_index, mispredict,
        output spec_ghr_out
    );
endinterface

// File: rtl/bp_history_ctrl.sv
// bp_history_ctrl: global-history manager for a gshare PHT.
//
// Fetch side: the lookup index is the speculative GHR XOR the fetch PC word
// bits. Every committed prediction is shifted into the speculative GHR, and
// its {index, predicted direction} is queued in a small in-flight FIFO.
//
// Resolve side: each ID resolution pops the oldest record. The commit GHR
// shifts by the real outcome, and a registered PHT update triple
// (is_last_branch, is_last_taken, last_index) is produced one cycle later.
// On a mispredict or a flush, the speculative GHR is rebuilt from the commit
// GHR and all younger in-flight records are discarded.
//
// Optional build macro:
//   BP_STAT_EN - adds the 32-bit counters stat_branches (accepted resolves)
//                and stat_mispredicts (mispredicted resolves). The counters
//                wrap, clear on reset and are unaffected by flush.
//
// Reset: synchronous, active-low (rst == 0 resets on posedge clk).
module bp_history_ctrl #(
    parameter int GHR_WIDTH  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bp_history_ctrl_if.slave      bp
`ifdef BP_STAT_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [GHR_WIDTH-1:0] spec_ghr_q,   spec_ghr_d;
    logic [GHR_WIDTH-1:0] commit_ghr_q, commit_ghr_d;
    logic [PTR_W-1:0]     head_q,       head_d;
    logic [PTR_W-1:0]     tail_q,       tail_d;
    logic [CNT_W-1:0]     count_q,      count_d;

    // In-flight record storage. It needs no reset: count_q qualifies it.
    logic [GHR_WIDTH-1:0] fifo_idx_q [FIFO_DEPTH];
    logic                 fifo_tk_q  [FIFO_DEPTH];

    // Registered PHT update outputs
    logic                 is_last_branch_q, is_last_branch_d;
    logic                 is_last_taken_q,  is_last_taken_d;
    logic [GHR_WIDTH-1:0] last_index_q,     last_index_d;
    logic                 mispredict_q,     mispredict_d;

    // ------------------------------------------------------------------
    // Fetch-side combinational terms
    // ------------------------------------------------------------------
    logic [GHR_WIDTH-1:0] index_w;
    logic                 pred_ready_w;
    logic                 push_ok;
    logic                 res_ok;
    logic                 res_wrong;
    logic                 push_commit;
    logic [GHR_WIDTH-1:0] head_idx;
    logic                 head_tk;
    logic [GHR_WIDTH-1:0] commit_shifted;

    // PC bits above and below the index field are not part of the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.fetch_pc[31:GHR_WIDTH+2], bp.fetch_pc[1:0]};

    assign index_w      = spec_ghr_q ^ bp.fetch_pc[GHR_WIDTH+1:2];
    assign pred_ready_w = (count_q != CNT_FULL);

    assign head_idx = fifo_idx_q[head_q];
    assign head_tk  = fifo_tk_q[head_q];

    assign push_ok   = bp.pred_fire && pred_ready_w;
    assign res_ok    = bp.resolve_valid && (count_q != '0);
    assign res_wrong = res_ok && (head_tk != bp.resolve_taken);

    // A push is real only if no flush or mispredict squashes the fetch path
    // it came from in the same cycle.
    assign push_commit = push_ok && !bp.flush && !res_wrong;

    // Commit history extended by this cycle's outcome. It is the repair
    // value whenever a resolve coincides with a mispredict or flush.
    assign commit_shifted = {commit_ghr_q[GHR_WIDTH-2:0], bp.resolve_taken};

    // ------------------------------------------------------------------
    // Next-state for the history registers and FIFO bookkeeping
    // ------------------------------------------------------------------
    // Priority: flush > mispredict > normal push/pop.
    always_comb begin
        spec_ghr_d   = spec_ghr_q;
        commit_ghr_d = commit_ghr_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;

        if (res_ok) begin
            commit_ghr_d = commit_shifted;
        end

        if (bp.flush) begin
            // Drop everything in flight and restart from architectural history.
            count_d     = '0;
            head_d      = tail_q;
            spec_ghr_d  = res_ok ? commit_shifted : commit_ghr_q;
        end else if (res_wrong) begin
            // Wrong direction: all younger records are on the wrong path.
            count_d     = '0;
            head_d      = tail_q;
            spec_ghr_d  = commit_shifted;
        end else begin
            if (push_ok) begin
                tail_d     = tail_q + PTR_W'(1);
                spec_ghr_d = {spec_ghr_q[GHR_WIDTH-2:0], bp.pred_taken};
            end
            if (res_ok) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push_ok, res_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state for the registered PHT update
    // ------------------------------------------------------------------
    // Strobes are single-cycle. Index and direction hold between updates.
    always_comb begin
        is_last_branch_d = 1'b0;
        mispredict_d     = 1'b0;
        is_last_taken_d  = is_last_taken_q;
        last_index_d     = last_index_q;

        if (res_ok) begin
            is_last_branch_d = 1'b1;
            is_last_taken_d  = bp.resolve_taken;
            last_index_d     = head_idx;
            mispredict_d     = res_wrong;
        end
    end

    // History, pointer and update-output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            spec_ghr_q       <= '0;
            commit_ghr_q     <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            is_last_branch_q <= 1'b0;
            is_last_taken_q  <= 1'b0;
            last_index_q     <= '0;
            mispredict_q     <= 1'b0;
        end else begin
            spec_ghr_q       <= spec_ghr_d;
            commit_ghr_q     <= commit_ghr_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            is_last_branch_q <= is_last_branch_d;
            is_last_taken_q  <= is_last_taken_d;
            last_index_q     <= last_index_d;
            mispredict_q     <= mispredict_d;
        end
    end

    // Capture the in-flight record at the tail on every committed push
    always_ff @(posedge clk) begin
        if (push_commit) begin
            fifo_idx_q[tail_q] <= index_w;
            fifo_tk_q[tail_q]  <= bp.pred_taken;
        end
    end

`ifdef BP_STAT_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    // Resolve and mispredict counters. They wrap naturally and ignore flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (res_ok) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (res_wrong) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bp.index          = index_w;
    assign bp.pred_ready     = pred_ready_w;
    assign bp.is_last_branch = is_last_branch_q;
    assign bp.is_last_taken  = is_last_taken_q;
    assign bp.last_index     = last_index_q;
    assign bp.mispredict     = mispredict_q;
    assign bp.spec_ghr_out   = spec_ghr_q;

endmodule

// File: tb/tb_bp_history_ctrl.sv
// tb_bp_history_ctrl: directed test of bp_history_ctrl with hand-computed
// expected values (GHR_WIDTH=5, FIFO_DEPTH=4). Inputs change 1 ns after a
// rising edge, and outputs are sampled at that same point.
module tb_bp_history_ctrl;

    localparam int GW = 5;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bp_history_ctrl_if #(.GHR_WIDTH(GW)) bp_if ();

`ifdef BP_STAT_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    bp_history_ctrl #(
        .GHR_WIDTH  (GW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bp               (bp_if)
`ifdef BP_STAT_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bp_if.pred_taken    = 1'b0;
        bp_if.pred_fire     = 1'b0;
        bp_if.resolve_valid = 1'b0;
        bp_if.resolve_taken = 1'b0;
        bp_if.flush         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        bp_if.fetch_pc = 32'h0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic push(input logic tk, input logic [31:0] pc);
        bp_if.fetch_pc   = pc;
        bp_if.pred_taken = tk;
        bp_if.pred_fire  = 1'b1;
        tick();
        bp_if.pred_fire  = 1'b0;
        bp_if.pred_taken = 1'b0;
    endtask

    task automatic resolve(input logic tk);
        bp_if.resolve_valid = 1'b1;
        bp_if.resolve_taken = tk;
        tick();
        bp_if.resolve_valid = 1'b0;
        bp_if.resolve_taken = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        bp_if.fetch_pc = 32'h0000_0040;
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bp_if.is_last_branch !== 1'b0) begin
            n_errors++; $display("FAIL reset_ilb: got %b want 0", bp_if.is_last_branch);
        end
        n_checks++;
        if (bp_if.mispredict !== 1'b0) begin
            n_errors++; $display("FAIL reset_mp: got %b want 0", bp_if.mispredict);
        end
        n_checks++;
        if (bp_if.last_index !== 5'h00) begin
            n_errors++; $display("FAIL reset_li: got %h want 00", bp_if.last_index);
        end
        n_checks++;
        if (bp_if.spec_ghr_out !== 5'h00) begin
            n_errors++; $display("FAIL reset_ghr: got %h want 00", bp_if.spec_ghr_out);
        end
        n_checks++;
        if (bp_if.index !== 5'h10) begin
            n_errors++; $display("FAIL reset_index: got %h want 10", bp_if.index);
        end
        n_checks++;
        if (bp_if.pred_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready: got %b want 1", bp_if.pred_ready);
        end
        rst = 1'b1;
    endtask

    task automatic test_correct_predict();
        bp_if.fetch_pc   = 32'h0000_0040;
        bp_if.pred_taken = 1'b1;
        bp_if.pred_fire  = 1'b1;
        #1;
        n_checks++;
        if (bp_if.index !== 5'h10) begin
            n_errors++; $display("FAIL cp_index: got %h want 10", bp_if.index);
        end
        tick();
        bp_if.pred_fire  = 1'b0;
        bp_if.pred_taken = 1'b0;
        n_checks++;
        if (bp_if.spec_ghr_out !== 5'b00001) begin
            n_errors++; $display("FAIL cp_ghr: got %b want 00001", bp_if.spec_ghr_out);
        end
        resolve(1'b1);
        n_checks++;
        if ({bp_if.is_last_branch, bp_if.is_last_taken, bp_if.mispredict} !== 3'b110) begin
            n_errors++; $display("FAIL cp_strobe: got ilb/ilt/mp=%b%b%b want 110",
                bp_if.is_last_branch, bp_if.is_last_taken, bp_if.mispredict);
        end
        n_checks++;
        if (bp_if.last_index !== 5'h10) begin
            n_errors++; $display("FAIL cp_li: got %h want 10", bp_if.last_index);
        end
        tick();
        n_checks++;
        if ({bp_if.is_last_branch, bp_if.is_last_taken, bp_if.last_index} !== {2'b01, 5'h10}) begin
            n_errors++; $display("FAIL cp_hold: got ilb=%b ilt=%b li=%h want 0 1 10",
                bp_if.is_last_branch, bp_if.is_last_taken, bp_if.last_index);
        end
    endtask

    task automatic test_full();
        logic [4:0] push_idx [4];
        logic       push_tk  [4];
        logic [4:0] drain_idx [4];
        logic       drain_tk  [4];
        push_idx  = '{5'h01, 5'h03, 5'h06, 5'h0D};
        push_tk   = '{1'b1, 1'b0, 1'b1, 1'b1};
        drain_idx = '{5'h06, 5'h0D, 5'h1B, 5'h17};
        drain_tk  = '{1'b1, 1'b1, 1'b0, 1'b1};
        // Starts with spec = commit = 00001, nothing in flight.
        bp_if.fetch_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            bp_if.pred_taken = push_tk[i];
            bp_if.pred_fire  = 1'b1;
            #1;
            n_checks++;
            if (bp_if.index !== push_idx[i]) begin
                n_errors++; $display("FAIL full_push_index[%0d]: got %h want %h", i, bp_if.index, push_idx[i]);
            end
            tick();
        end
        idle_inputs();
        n_checks++;
        if ({bp_if.pred_ready, bp_if.spec_ghr_out} !== {1'b0, 5'h1B}) begin
            n_errors++; $display("FAIL full_state: got ready=%b ghr=%h want 0 1b", bp_if.pred_ready, bp_if.spec_ghr_out);
        end
        // Push against a full FIFO is ignored.
        push(1'b0, 32'h0);
        n_checks++;
        if ({bp_if.pred_ready, bp_if.spec_ghr_out, bp_if.is_last_branch} !== {1'b0, 5'h1B, 1'b0}) begin
            n_errors++; $display("FAIL full_blocked: got ready=%b ghr=%h ilb=%b want 0 1b 0",
                bp_if.pred_ready, bp_if.spec_ghr_out, bp_if.is_last_branch);
        end
        // Correct resolve while full: the attempted push still blocked.
        bp_if.pred_fire = 1'b1;
        resolve(1'b1);
        bp_if.pred_fire = 1'b0;
        n_checks++;
        if ({bp_if.is_last_branch, bp_if.mispredict, bp_if.last_index, bp_if.spec_ghr_out, bp_if.pred_ready}
                !== {2'b10, 5'h01, 5'h1B, 1'b1}) begin
            n_errors++; $display("FAIL full_res: got ilb=%b mp=%b li=%h ghr=%h ready=%b want 1 0 01 1b 1",
                bp_if.is_last_branch, bp_if.mispredict, bp_if.last_index, bp_if.spec_ghr_out, bp_if.pred_ready);
        end
        // Push and correct resolve in the same cycle: count stays 3.
        bp_if.pred_fire     = 1'b1;
        bp_if.pred_taken    = 1'b0;
        bp_if.resolve_valid = 1'b1;
        bp_if.resolve_taken = 1'b0;
        #1;
        n_checks++;
        if (bp_if.index !== 5'h1B) begin
            n_errors++; $display("FAIL b2b_index: got %h want 1b", bp_if.index);
        end
        tick();
        idle_inputs();
        n_checks++;
        if ({bp_if.is_last_branch, bp_if.is_last_taken, bp_if.mispredict, bp_if.last_index, bp_if.spec_ghr_out, bp_if.pred_ready}
                !== {3'b100, 5'h03, 5'h16, 1'b1}) begin
            n_errors++; $display("FAIL b2b_state: got ilb=%b ilt=%b mp=%b li=%h ghr=%h ready=%b want 1 0 0 03 16 1",
                bp_if.is_last_branch, bp_if.is_last_taken, bp_if.mispredict, bp_if.last_index,
                bp_if.spec_ghr_out, bp_if.pred_ready);
        end
        // One more push wraps the tail and refills to four.
        bp_if.fetch_pc   = 32'h4;
        bp_if.pred_taken = 1'b1;
        bp_if.pred_fire  = 1'b1;
        #1;
        n_checks++;
        if (bp_if.index !== 5'h17) begin
            n_errors++; $display("FAIL wrap_index: got %h want 17", bp_if.index);
        end
        tick();
        idle_inputs();
        bp_if.fetch_pc = 32'h0;
        n_checks++;
        if ({bp_if.pred_ready, bp_if.spec_ghr_out} !== {1'b0, 5'h0D}) begin
            n_errors++; $display("FAIL refill: got ready=%b ghr=%h want 0 0d", bp_if.pred_ready, bp_if.spec_ghr_out);
        end
        // Back-to-back correct resolves drain the wrapped FIFO in order.
        for (int i = 0; i < 4; i++) begin
            resolve(drain_tk[i]);
            n_checks++;
            if ({bp_if.is_last_branch, bp_if.mispredict, bp_if.is_last_taken, bp_if.last_index}
                    !== {2'b10, drain_tk[i], drain_idx[i]}) begin
                n_errors++; $display("FAIL drain[%0d]: got ilb=%b mp=%b ilt=%b li=%h want 1 0 %b %h", i,
                    bp_if.is_last_branch, bp_if.mispredict, bp_if.is_last_taken, bp_if.last_index,
                    drain_tk[i], drain_idx[i]);
            end
        end
        tick();
        n_checks++;
        if ({bp_if.is_last_branch, bp_if.pred_ready, bp_if.spec_ghr_out} !== {2'b01, 5'h0D}) begin
            n_errors++; $display("FAIL drained: got ilb=%b ready=%b ghr=%h want 0 1 0d",
                bp_if.is_last_branch, bp_if.pred_ready, bp_if.spec_ghr_out);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        push(1'b1, 32'h0);
        push(1'b1, 32'h0);
        push(1'b1, 32'h0);
        n_checks++;
        if (bp_if.spec_ghr_out !== 5'b00111) begin
            n_errors++; $display("FAIL mp_pre_ghr: got %b want 00111", bp_if.spec_ghr_out);
        end
        // Wrong resolve with a same-cycle push that must be dropped.
        bp_if.pred_fire  = 1'b1;
        bp_if.pred_taken = 1'b1;
        resolve(1'b0);
        idle_inputs();
        n_checks++;
        if ({bp_if.is_last_branch, bp_if.mispredict, bp_if.is_last_taken, bp_if.last_index} !== {3'b110, 5'h00}) begin
            n_errors++; $display("FAIL mp_strobe: got ilb=%b mp=%b ilt=%b li=%h want 1 1 0 00",
                bp_if.is_last_branch, bp_if.mispredict, bp_if.is_last_taken, bp_if.last_index);
        end
        n_checks++;
        if ({bp_if.spec_ghr_out, bp_if.pred_ready} !== {5'h00, 1'b1}) begin
            n_errors++; $display("FAIL mp_repair: got ghr=%b ready=%b want 00000 1", bp_if.spec_ghr_out, bp_if.pred_ready);
        end
        // FIFO must be empty: the next resolve is ignored.
        resolve(1'b1);
        n_checks++;
        if ({bp_if.is_last_branch, bp_if.mispredict, bp_if.spec_ghr_out} !== {2'b00, 5'h00}) begin
            n_errors++; $display("FAIL mp_empty: got ilb=%b mp=%b ghr=%h want 0 0 00",
                bp_if.is_last_branch, bp_if.mispredict, bp_if.spec_ghr_out);
        end
    endtask

    task automatic test_flush();
        do_reset();
        push(1'b1, 32'h0);
        push(1'b1, 32'h0);
        resolve(1'b1);
        resolve(1'b1);
        n_checks++;
        if ({bp_if.is_last_branch, bp_if.last_index} !== {1'b1, 5'h01}) begin
            n_errors++; $display("FAIL fl_commit: got ilb=%b li=%h want 1 01", bp_if.is_last_branch, bp_if.last_index);
        end
        push(1'b1, 32'h0);
        push(1'b1, 32'h0);
        n_checks++;
        if (bp_if.spec_ghr_out !== 5'h0F) begin
            n_errors++; $display("FAIL fl_pre_ghr: got %b want 01111", bp_if.spec_ghr_out);
        end
        // Flush with a same-cycle push: both in-flight records and the push die.
        bp_if.flush      = 1'b1;
        bp_if.pred_fire  = 1'b1;
        bp_if.pred_taken = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if ({bp_if.spec_ghr_out, bp_if.is_last_branch, bp_if.pred_ready} !== {5'h03, 2'b01}) begin
            n_errors++; $display("FAIL fl_state: got ghr=%b ilb=%b ready=%b want 00011 0 1",
                bp_if.spec_ghr_out, bp_if.is_last_branch, bp_if.pred_ready);
        end
        resolve(1'b1);
        n_checks++;
        if ({bp_if.is_last_branch, bp_if.spec_ghr_out} !== {1'b0, 5'h03}) begin
            n_errors++; $display("FAIL fl_empty: got ilb=%b ghr=%h want 0 03", bp_if.is_last_branch, bp_if.spec_ghr_out);
        end
        // Flush together with a correct resolve: the pop and update survive.
        push(1'b1, 32'h0);
        push(1'b0, 32'h0);
        n_checks++;
        if (bp_if.spec_ghr_out !== 5'h0E) begin
            n_errors++; $display("FAIL flr_pre_ghr: got %b want 01110", bp_if.spec_ghr_out);
        end
        bp_if.flush = 1'b1;
        resolve(1'b1);
        idle_inputs();
        n_checks++;
        if ({bp_if.spec_ghr_out, bp_if.is_last_branch, bp_if.mispredict, bp_if.last_index}
                !== {5'h07, 2'b10, 5'h03}) begin
            n_errors++; $display("FAIL flr_state: got ghr=%b ilb=%b mp=%b li=%h want 00111 1 0 03",
                bp_if.spec_ghr_out, bp_if.is_last_branch, bp_if.mispredict, bp_if.last_index);
        end
        resolve(1'b0);
        n_checks++;
        if ({bp_if.is_last_branch, bp_if.spec_ghr_out} !== {1'b0, 5'h07}) begin
            n_errors++; $display("FAIL flr_empty: got ilb=%b ghr=%h want 0 07", bp_if.is_last_branch, bp_if.spec_ghr_out);
        end
    endtask

`ifdef BP_STAT_EN
    task automatic test_stats();
        do_reset();
        n_checks++;
        if ({stat_branches, stat_mispredicts} !== 64'h0) begin
            n_errors++; $display("FAIL stat_reset0: got %0d %0d want 0 0", stat_branches, stat_mispredicts);
        end
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 32'h0);
            resolve(i < 3);
        end
        n_checks++;
        if (stat_branches !== 32'd5) begin
            n_errors++; $display("FAIL stat_branches: got %0d want 5", stat_branches);
        end
        n_checks++;
        if (stat_mispredicts !== 32'd2) begin
            n_errors++; $display("FAIL stat_mispredicts: got %0d want 2", stat_mispredicts);
        end
        do_reset();
        n_checks++;
        if ({stat_branches, stat_mispredicts} !== 64'h0) begin
            n_errors++; $display("FAIL stat_reset1: got %0d %0d want 0 0", stat_branches, stat_mispredicts);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bp_if.fetch_pc = 32'h0;
        idle_inputs();

        test_reset();
        test_correct_predict();
        test_full();
        test_mispredict();
        test_flush();
`ifdef BP_STAT_EN
        test_stats();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
